uart_rx: RTL and testbench
==========================

// Module: uart_rx
//
// PURPOSE
//   UART receiver that consumes the 16x-oversampling tick of BaudRateGenerator.
//   Deserialises an asynchronous serial line (start bit, DATA_BITS LSB-first, stop bit).
//   Presents each received byte on dout with a one-cycle rx_done strobe.
//   Sits between the baud generator and the downstream consumer (FIFO/interface FSM).
//
// PARAMETERS
//   DATA_BITS  8   data bits per frame, range 5..8
//   SB_TICKS   16  ticks counted in the stop bit (16 = 1 stop bit, 24 = 1.5, 32 = 2)
//
// PORTS
//   clk        in   1          system clock; all logic on rising edge
//   rst        in   1          asynchronous, active-low reset
//   tick       in   1          1-clk pulse from BaudRateGenerator, 16 per bit period
//   rx         in   1          serial line, idle high, asynchronous to clk
//   dout       out  DATA_BITS  last received data word
//   rx_done    out  1          1-clk pulse: dout updated with a new word
//   frame_err  out  1          stop-bit sample of the last frame was 0
//   busy       out  1          high while a frame is in progress (state != IDLE)
//
// BEHAVIOUR
//   - rx passes through a 2-FF synchroniser; both FFs reset to 1; the FSM sees only the synced value.
//   - Reset (rst=0, async): state=IDLE, s_cnt=0, n=0, shift=0.
//     Outputs: dout=0, rx_done=0, frame_err=0, busy=0. Takes effect mid-frame too; the partial frame is discarded.
//   - s_cnt 5 bits; n 3 bits. Counters advance only on cycles with tick=1; other cycles hold.
//   - FSM states IDLE, START, DATA, STOP:
//     IDLE : on synced rx=0 (any cycle, tick not needed) -> START, s_cnt=0.
//     START: on tick, s_cnt==7 (mid start bit):
//              rx=0 -> DATA, s_cnt=0, n=0;
//              rx=1 -> IDLE (glitch rejected, no strobe).
//            Otherwise s_cnt++.
//     DATA : on tick, s_cnt==15: shift={rx, shift[DATA_BITS-1:1]} (LSB first), s_cnt=0;
//              n==DATA_BITS-1 -> STOP, else n++.
//            Otherwise s_cnt++.
//     STOP : on tick, s_cnt==SB_TICKS-1: dout<=shift, frame_err<=~rx, rx_done<=1, -> IDLE.
//            Otherwise s_cnt++.
//   - Bits are sampled at mid-bit. The return to IDLE occurs at the stop-bit sample point,
//     so a start bit immediately following the stop bit is caught.
//   - rx_done is registered: high exactly one clk cycle, the cycle after the completing tick.
//     dout and frame_err change on the same edge that raises rx_done and hold until the next frame completes.
//   - A frame with a bad stop bit is still delivered: rx_done=1, frame_err=1, dout=received data.
//   - tick while IDLE is ignored. rx changes between ticks are ignored except the IDLE start detect.
//   - busy = (state != IDLE), registered with the state.
//   - No overrun detection; the consumer must take dout before the next rx_done.
//
// TESTING  (bench: tick = 1-clk pulse every 4 clk -> bit period 64 clk; default params)
//   1. Frame 0x55, 1 stop bit
//      -> single rx_done pulse ~9.5 bit periods after start edge; dout=0x55, frame_err=0.
//   2. Back-to-back 0xA3 then 0x0F, no idle gap
//      -> two rx_done pulses; dout=0xA3 then 0x0F; frame_err=0 both.
//   3. rx low for 3 ticks, then high (glitch)
//      -> no rx_done; busy=1 then 0 after the 8th tick; following frame 0x81 received correctly.
//   4. Data 0xFF with stop bit driven 0
//      -> rx_done pulses, dout=0xFF, frame_err=1; next good frame 0x12 clears frame_err to 0.
//   5. rst=0 during DATA bit 4
//      -> dout=0, rx_done=0, busy=0 immediately; after release, frame 0x3C gives dout=0x3C.
//   6. DATA_BITS=7, SB_TICKS=32, frame 0x41 with 2 stop bits
//      -> dout=7'h41, frame_err=0, exactly one rx_done.

Source files
------------

// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx
//
// UART receiver driven by a 16x-oversampling tick from the baud generator.
// It deserialises an idle-high asynchronous line (start bit, DATA_BITS data
// bits LSB first, stop bit) and presents each word on dout with a one-cycle
// rx_done strobe.
//
// Parameters
//   DATA_BITS  data bits per frame (5..8)
//   SB_TICKS   ticks counted in the stop bit (16 = 1, 24 = 1.5, 32 = 2 bits)
//
// Ports
//   clk        system clock, rising edge
//   rst        asynchronous, active-low reset
//   tick       1-clk pulse, 16 per bit period
//   rx         serial line, idle high, asynchronous to clk
//   dout       last received data word
//   rx_done    1-clk pulse: dout/frame_err just updated with a new word
//   frame_err  stop-bit sample of the last frame was 0
//   busy       high while a frame is in progress (state != IDLE)
//   dbg_state  current FSM state (0 IDLE, 1 START, 2 DATA, 3 STOP)
//
// Handshake: output only, no backpressure. rx_done is high for exactly one
// clk cycle; dout and frame_err change on that same edge and hold until the
// next frame completes. The consumer must take dout before the next rx_done.
// -----------------------------------------------------------------------------
module uart_rx #(
  parameter int DATA_BITS = 8,
  parameter int SB_TICKS  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 tick,
  input  logic                 rx,
  output logic [DATA_BITS-1:0] dout,
  output logic                 rx_done,
  output logic                 frame_err,
  output logic                 busy,
  output logic [1:0]           dbg_state
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } state_t;

  localparam logic [4:0] MID_START = 5'd7;
  localparam logic [4:0] BIT_LAST  = 5'd15;
  localparam logic [4:0] SB_LAST   = 5'(SB_TICKS - 1);
  localparam logic [2:0] N_LAST    = 3'(DATA_BITS - 1);

  // Two-flop synchroniser; reset to the idle level so a reset never looks
  // like a start bit.
  logic rx_s1, rx_s2;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
    end else begin
      rx_s1 <= rx;
      rx_s2 <= rx_s1;
    end
  end

  state_t               state, state_n;
  logic [4:0]           s_cnt, s_cnt_n;
  logic [2:0]           n, n_n;
  logic [DATA_BITS-1:0] shift, shift_n;
  logic [DATA_BITS-1:0] dout_n;
  logic                 frame_err_n;
  logic                 rx_done_n;
  logic                 busy_n;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= IDLE;
      s_cnt     <= 5'd0;
      n         <= 3'd0;
      shift     <= '0;
      dout      <= '0;
      frame_err <= 1'b0;
      rx_done   <= 1'b0;
      busy      <= 1'b0;
    end else begin
      state     <= state_n;
      s_cnt     <= s_cnt_n;
      n         <= n_n;
      shift     <= shift_n;
      dout      <= dout_n;
      frame_err <= frame_err_n;
      rx_done   <= rx_done_n;
      busy      <= busy_n;
    end
  end

  always_comb begin
    state_n     = state;
    s_cnt_n     = s_cnt;
    n_n         = n;
    shift_n     = shift;
    dout_n      = dout;
    frame_err_n = frame_err;
    rx_done_n   = 1'b0;

    case (state)
      // Start detect does not wait for a tick, so the mid-bit phase is set
      // by the actual falling edge rather than by tick alignment.
      IDLE: begin
        if (!rx_s2) begin
          state_n = START;
          s_cnt_n = 5'd0;
        end
      end

      // Eight ticks in is the middle of the start bit; a high line there
      // means the falling edge was a glitch.
      START: begin
        if (tick) begin
          if (s_cnt == MID_START) begin
            if (!rx_s2) begin
              state_n = DATA;
              s_cnt_n = 5'd0;
              n_n     = 3'd0;
            end else begin
              state_n = IDLE;
            end
          end else begin
            s_cnt_n = s_cnt + 5'd1;
          end
        end
      end

      // From the start-bit midpoint, every 16 ticks lands on a data midpoint.
      DATA: begin
        if (tick) begin
          if (s_cnt == BIT_LAST) begin
            shift_n = {rx_s2, shift[DATA_BITS-1:1]};
            s_cnt_n = 5'd0;
            if (n == N_LAST) begin
              state_n = STOP;
            end else begin
              n_n = n + 3'd1;
            end
          end else begin
            s_cnt_n = s_cnt + 5'd1;
          end
        end
      end

      // Leaving at the stop sample point (not the end of the stop bit) lets
      // a start bit that immediately follows be caught.
      STOP: begin
        if (tick) begin
          if (s_cnt == SB_LAST) begin
            dout_n      = shift;
            frame_err_n = ~rx_s2;
            rx_done_n   = 1'b1;
            state_n     = IDLE;
          end else begin
            s_cnt_n = s_cnt + 5'd1;
          end
        end
      end

      default: begin
        state_n = IDLE;
      end
    endcase

    busy_n = (state_n != IDLE);
  end

  assign dbg_state = state;

endmodule

// File: tb/tb_uart_rx.sv
// -----------------------------------------------------------------------------
// tb_uart_rx
//
// Directed bench for uart_rx. tick is a 1-clk pulse every 4 clk, so one bit
// period is 64 clk. u_dut uses default parameters; u_dut7 uses DATA_BITS=7,
// SB_TICKS=32 and has its own serial line.
// -----------------------------------------------------------------------------
module tb_uart_rx;

  localparam int BIT_CLKS = 64;

  // ---------------------------------------------------------------- clock/reset
  logic clk  = 1'b0;
  logic rst  = 1'b0;
  logic tick = 1'b0;
  logic rx   = 1'b1;
  logic rx7  = 1'b1;

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    int ph;
    ph = 0;
    forever begin
      @(negedge clk);
      tick = (ph == 3);
      ph   = (ph + 1) % 4;
    end
  end

  // ---------------------------------------------------------------- DUTs
  logic [7:0] dout;
  logic       rx_done, frame_err, busy;
  logic [1:0] dbg_state;

  logic [6:0] dout7;
  logic       rx_done7, frame_err7, busy7;
  logic [1:0] dbg_state7;

  uart_rx #(.DATA_BITS(8), .SB_TICKS(16)) u_dut (
    .clk       (clk),
    .rst       (rst),
    .tick      (tick),
    .rx        (rx),
    .dout      (dout),
    .rx_done   (rx_done),
    .frame_err (frame_err),
    .busy      (busy),
    .dbg_state (dbg_state)
  );

  uart_rx #(.DATA_BITS(7), .SB_TICKS(32)) u_dut7 (
    .clk       (clk),
    .rst       (rst),
    .tick      (tick),
    .rx        (rx7),
    .dout      (dout7),
    .rx_done   (rx_done7),
    .frame_err (frame_err7),
    .busy      (busy7),
    .dbg_state (dbg_state7)
  );

  // ---------------------------------------------------------------- scoreboard
  // Each rx_done cycle pushes {frame_err, dout}; a stretched strobe pushes
  // twice and shows up as an extra word.
  logic [8:0] got_q[$];
  logic [7:0] got7_q[$];
  logic [8:0] exp_q[$];
  int         done_cyc = 0;

  always @(negedge clk) begin
    if (rx_done === 1'b1) begin
      got_q.push_back({frame_err, dout});
      done_cyc = cyc;
    end
    if (rx_done7 === 1'b1) begin
      got7_q.push_back({frame_err7, dout7});
    end
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Compare every queued expected word against the received words, then
  // require that nothing extra arrived.
  task automatic drain(input string tag);
    logic [8:0] e, g;
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check({tag, "_avail"}, 32'(got_q.size() > 0), 32'd1);
      if (got_q.size() > 0) begin
        g = got_q.pop_front();
        check({tag, "_word"}, 32'(g), 32'(e));
      end
    end
    check({tag, "_extra"}, 32'(got_q.size()), 32'd0);
  endtask

  // ---------------------------------------------------------------- drivers
  // All drivers are entered on a negedge and return on a negedge.
  task automatic hold(input logic v, input bit sel7, input int clks);
    if (sel7) rx7 = v;
    else      rx  = v;
    repeat (clks) @(negedge clk);
  endtask

  task automatic send_frame(input logic [7:0] data, input int nbits,
                            input logic stop_val, input int stop_clks, input bit sel7);
    hold(1'b0, sel7, BIT_CLKS);
    for (int i = 0; i < nbits; i++) hold(data[i], sel7, BIT_CLKS);
    hold(stop_val, sel7, stop_clks);
    if (sel7) rx7 = 1'b1;
    else      rx  = 1'b1;
  endtask

  // ---------------------------------------------------------------- stimulus
  initial begin
    int start_cyc;
    int lat;
    int base;

    // Reset state
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_dout",      32'(dout),      32'h0);
    check("rst_rx_done",   32'(rx_done),   32'h0);
    check("rst_frame_err", 32'(frame_err), 32'h0);
    check("rst_busy",      32'(busy),      32'h0);
    check("rst_state",     32'(dbg_state), 32'h0);
    rst = 1'b1;
    repeat (10) @(negedge clk);

    // 1. Single frame 0x55; rx_done ~9.5 bit periods (608 clk) after start edge
    start_cyc = cyc;
    exp_q.push_back({1'b0, 8'h55});
    send_frame(8'h55, 8, 1'b1, BIT_CLKS, 1'b0);
    hold(1'b1, 1'b0, 32);
    lat = done_cyc - start_cyc;
    check("t1_latency_ok", 32'(lat >= 600 && lat <= 620), 32'd1);
    check("t1_busy_idle", 32'(busy), 32'h0);
    drain("t1");

    // 2. Back-to-back frames with no idle gap
    exp_q.push_back({1'b0, 8'hA3});
    exp_q.push_back({1'b0, 8'h0F});
    send_frame(8'hA3, 8, 1'b1, BIT_CLKS, 1'b0);
    send_frame(8'h0F, 8, 1'b1, BIT_CLKS, 1'b0);
    hold(1'b1, 1'b0, 32);
    drain("t2");

    // 3. Glitch: low for 3 ticks (12 clk), rejected at the 8th tick
    hold(1'b0, 1'b0, 10);
    check("t3_busy_start", 32'(busy), 32'h1);
    check("t3_state_start", 32'(dbg_state), 32'h1);
    hold(1'b0, 1'b0, 2);
    hold(1'b1, 1'b0, 18);
    check("t3_busy_before_8th", 32'(busy), 32'h1);
    hold(1'b1, 1'b0, 10);
    check("t3_busy_after_8th", 32'(busy), 32'h0);
    hold(1'b1, 1'b0, 200);
    check("t3_no_done", 32'(got_q.size()), 32'd0);
    exp_q.push_back({1'b0, 8'h81});
    send_frame(8'h81, 8, 1'b1, BIT_CLKS, 1'b0);
    hold(1'b1, 1'b0, 32);
    drain("t3");

    // 4. Bad stop bit: 0xFF delivered with frame_err; low stop held past the
    //    sample point only, so the follow-on start detect is rejected
    exp_q.push_back({1'b1, 8'hFF});
    send_frame(8'hFF, 8, 1'b0, 48, 1'b0);
    hold(1'b1, 1'b0, 2 * BIT_CLKS);
    check("t4_frame_err_set", 32'(frame_err), 32'h1);
    drain("t4_bad");
    exp_q.push_back({1'b0, 8'h12});
    send_frame(8'h12, 8, 1'b1, BIT_CLKS, 1'b0);
    hold(1'b1, 1'b0, 32);
    check("t4_frame_err_clear", 32'(frame_err), 32'h0);
    drain("t4_good");

    // 5. Reset during data bit 4
    hold(1'b0, 1'b0, BIT_CLKS);
    for (int i = 0; i < 4; i++) hold(1'b0, 1'b0, BIT_CLKS);
    hold(1'b1, 1'b0, 20);
    check("t5_busy_pre", 32'(busy), 32'h1);
    check("t5_state_data", 32'(dbg_state), 32'h2);
    check("t5_dout_pre", 32'(dout), 32'h12);
    rst = 1'b0;
    #1;
    check("t5_rst_dout",    32'(dout),    32'h0);
    check("t5_rst_rx_done", 32'(rx_done), 32'h0);
    check("t5_rst_busy",    32'(busy),    32'h0);
    @(negedge clk);
    rx = 1'b1;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    hold(1'b1, 1'b0, 2 * BIT_CLKS);
    check("t5_no_done", 32'(got_q.size()), 32'd0);
    exp_q.push_back({1'b0, 8'h3C});
    send_frame(8'h3C, 8, 1'b1, BIT_CLKS, 1'b0);
    hold(1'b1, 1'b0, 32);
    drain("t5");

    // 6. DATA_BITS=7, SB_TICKS=32: frame 0x41 with 2 stop bits
    check("t6_quiet_before", 32'(got7_q.size()), 32'd0);
    send_frame(8'h41, 7, 1'b1, 2 * BIT_CLKS, 1'b1);
    hold(1'b1, 1'b1, 32);
    check("t6_done_count", 32'(got7_q.size()), 32'd1);
    if (got7_q.size() > 0) begin
      base = int'(got7_q.pop_front());
      check("t6_word", 32'(base), 32'h41);
    end
    check("t6_busy7_idle", 32'(busy7), 32'h0);
    check("t6_main_quiet", 32'(got_q.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
